// File: rtl/fp16_mul_seq_if.sv
// rtl/fp16_mul_seq_if.sv - start/operand/result bundle for the sequential binary16 multiplier.
interface fp16_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  flags;

  modport master (output start, a, b, input busy, done, result, flags);
  modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp16_mul_seq.sv
// rtl/fp16_mul_seq.sv - binary16 multiplier, 11-step shift-add, fixed 13-cycle latency.
// FP16_MUL_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fp16_mul_seq (
  input  logic           clk,
  input  logic           reset_n,
  fp16_mul_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MUL, NORM, OUT} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;

  state_t          state_q, state_d;
  special_t        spec_q, spec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [21:0]     acc_q, acc_d;
  logic [21:0]     mcand_q, mcand_d;
  logic [10:0]     mplier_q, mplier_d;
  logic signed [6:0] esum_q, esum_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     result_q, result_d;
  logic [2:0]      flags_q, flags_d;

  logic [4:0] ea, eb;
  logic [9:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea = bus.a[14:10];
  assign eb = bus.b[14:10];
  assign fa = bus.a[9:0];
  assign fb = bus.b[9:0];
  // Exponent field 0 covers subnormals too: they are flushed to zero.
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);
  assign a_inf  = (ea == 5'h1f) && (fa == 10'd0);
  assign b_inf  = (eb == 5'h1f) && (fb == 10'd0);
  assign a_nan  = (ea == 5'h1f) && (fa != 10'd0);
  assign b_nan  = (eb == 5'h1f) && (fb != 10'd0);

  logic [9:0]        norm_frac;
  logic signed [6:0] norm_e;
  logic              guard, sticky, round_inc;
  logic [10:0]       frac_sum;
  logic signed [6:0] e_rnd;

  always_comb begin
    if (acc_q[21]) begin
      norm_frac = acc_q[20:11];
      norm_e    = esum_q + 7'sd1;
      guard     = acc_q[10];
      sticky    = |acc_q[9:0];
    end else begin
      norm_frac = acc_q[19:10];
      norm_e    = esum_q;
      guard     = acc_q[9];
      sticky    = |acc_q[8:0];
    end
  end

`ifdef FP16_MUL_RNE_EN
  assign round_inc = guard & (sticky | norm_frac[0]);
`else
  logic unused_round;
  assign unused_round = guard ^ sticky;
  assign round_inc    = 1'b0;
`endif

  // A carry out of the fraction leaves frac_sum[9:0] at zero, i.e. 1.0 at e+1.
  assign frac_sum = {1'b0, norm_frac} + {10'd0, round_inc};
  assign e_rnd    = frac_sum[10] ? norm_e + 7'sd1 : norm_e;

  always_comb begin
    state_d  = state_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    esum_d   = esum_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = MUL;
          cnt_d    = 4'd0;
          acc_d    = 22'd0;
          mcand_d  = {11'd0, 1'b1, fa};
          mplier_d = {1'b1, fb};
          esum_d   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
          sign_d   = bus.a[15] ^ bus.b[15];
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            spec_d = SP_NAN;
          else if (a_inf || b_inf)
            spec_d = SP_INF;
          else if (a_zero || b_zero)
            spec_d = SP_ZERO;
          else
            spec_d = SP_NONE;
        end
      end
      MUL: begin
        if (mplier_q[0])
          acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = OUT;
        case (spec_q)
          SP_NAN:  begin result_d = 16'h7E00;                  flags_d = 3'b100; end
          SP_INF:  begin result_d = {sign_q, 5'h1f, 10'd0};    flags_d = 3'b000; end
          SP_ZERO: begin result_d = {sign_q, 15'd0};           flags_d = 3'b000; end
          default: begin
            if (e_rnd >= 7'sd31) begin
              result_d = {sign_q, 5'h1f, 10'd0};
              flags_d  = 3'b010;
            end else if (e_rnd <= 7'sd0) begin
              result_d = {sign_q, 15'd0};
              flags_d  = 3'b001;
            end else begin
              result_d = {sign_q, e_rnd[4:0], frac_sum[9:0]};
              flags_d  = 3'b000;
            end
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);
  assign done_d = (state_d == OUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      spec_q   <= SP_NONE;
      cnt_q    <= 4'd0;
      acc_q    <= 22'd0;
      mcand_q  <= 22'd0;
      mplier_q <= 11'd0;
      esum_q   <= 7'sd0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 3'b000;
    end else begin
      state_q  <= state_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      esum_q   <= esum_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;
endmodule

// File: tb/tb_fp16_mul_seq.sv
// tb/tb_fp16_mul_seq.sv - directed vector table plus overlap and reset sequences for fp16_mul_seq.
module tb_fp16_mul_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fp16_mul_seq_if m ();
  fp16_mul_seq dut (.clk(clk), .reset_n(reset_n), .bus(m));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for its done pulse; lat=0 on timeout.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       output logic [15:0] r, output logic [2:0] f, output int lat);
    @(negedge clk);
    m.start = 1'b1; m.a = ta; m.b = tb_v;
    @(posedge clk);
    #1 m.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (m.done) begin
        lat = n;
        break;
      end
    end
    r = m.result;
    f = m.flags;
  endtask

  logic [15:0] r;
  logic [2:0]  f;
  int          lat;
  int          dones;
  logic [15:0] seen;

  initial begin
    vecs[0]  = '{16'h4000, 16'h4200, 16'h4600, 3'b000};
    vecs[1]  = '{16'hC000, 16'h3800, 16'hBC00, 3'b000};
    vecs[2]  = '{16'h3E00, 16'h3E00, 16'h4080, 3'b000};
`ifdef FP16_MUL_RNE_EN
    vecs[3]  = '{16'h3E01, 16'h3E01, 16'h4082, 3'b000};
`else
    vecs[3]  = '{16'h3E01, 16'h3E01, 16'h4081, 3'b000};
`endif
    vecs[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b100};
    vecs[5]  = '{16'h7BFF, 16'h4000, 16'h7C00, 3'b010};
    vecs[6]  = '{16'h0400, 16'h0400, 16'h0000, 3'b001};
    vecs[7]  = '{16'h7C00, 16'h4000, 16'h7C00, 3'b000};
    vecs[8]  = '{16'h8000, 16'h4000, 16'h8000, 3'b000};
    vecs[9]  = '{16'h7E01, 16'h3C00, 16'h7E00, 3'b100};
    vecs[10] = '{16'h0001, 16'h4000, 16'h0000, 3'b000};
    vecs[11] = '{16'h3C00, 16'hBC00, 16'hBC00, 3'b000};
    vecs[12] = '{16'h0000, 16'hFC00, 16'h7E00, 3'b100};
    vecs[13] = '{16'hC400, 16'hC400, 16'h4C00, 3'b000};

    m.start = 1'b0; m.a = 16'h0; m.b = 16'h0;
    #12;
    check("reset_busy",   {31'd0, m.busy}, 32'd0);
    check("reset_done",   {31'd0, m.done}, 32'd0);
    check("reset_result", {16'd0, m.result}, 32'h0000);
    check("reset_flags",  {29'd0, m.flags}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back through the table: each start lands in the cycle after done.
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].a, vecs[i].b, r, f, lat);
      check($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d_flags", i), {29'd0, f}, {29'd0, vecs[i].flg});
      check($sformatf("vec%0d_latency", i), lat, 32'd13);
      check($sformatf("vec%0d_busy_at_done", i), {31'd0, m.busy}, 32'd1);
    end

    // Start pulsed mid-multiply must be ignored.
    @(negedge clk);
    m.start = 1'b1; m.a = 16'h4000; m.b = 16'h4200;
    @(posedge clk);
    #1 m.start = 1'b0;
    @(negedge clk);
    check("busy_after_accept", {31'd0, m.busy}, 32'd1);
    repeat (3) @(negedge clk);
    m.start = 1'b1; m.a = 16'h3C00; m.b = 16'h3C00;
    @(negedge clk);
    m.start = 1'b0;
    dones = 0;
    seen = 16'h0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (m.done) begin
        dones++;
        seen = m.result;
      end
    end
    check("overlap_done_count", dones, 32'd1);
    check("overlap_result", {16'd0, seen}, 32'h4600);
    check("idle_busy", {31'd0, m.busy}, 32'd0);

    // Reset in the sixth MUL cycle aborts the operation.
    @(negedge clk);
    m.start = 1'b1; m.a = 16'h7BFF; m.b = 16'h4000;
    @(posedge clk);
    #1 m.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy",   {31'd0, m.busy}, 32'd0);
    check("abort_done",   {31'd0, m.done}, 32'd0);
    check("abort_result", {16'd0, m.result}, 32'h0000);
    check("abort_flags",  {29'd0, m.flags}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m.done) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    do_op(16'h4000, 16'h4200, r, f, lat);
    check("post_reset_result",  {16'd0, r}, 32'h4600);
    check("post_reset_flags",   {29'd0, f}, 32'd0);
    check("post_reset_latency", lat, 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
